// File: rtl/uart_rx_core.sv
// Oversampled UART receiver: 2-flop line synchroniser, start validation, runtime parity, valid/ready holding register.
// Define UART_RX_MAJORITY_EN to make every bit decision a 2-of-3 majority around the sample point.
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 rx_enbl,
  input  logic                 info,
  input  logic                 p_enbl,
  input  logic                 p_odd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Majority decisions land one tick after the nominal sample point.
  localparam logic [TW-1:0] START_LAST = TW'(OVERSAMPLE / 2 - 1 + MAJ);
  localparam logic [TW-1:0] BIT_LAST   = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [1:0]           sync;
  logic                 rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_en_l;
  logic                 par_odd_l;
  logic                 par_bad;
  logic                 stop_bad;
  logic                 bit_val;
  logic                 sample_pt;
  logic                 last_bad;

  assign rx_s = sync[1];
  assign busy = (state != IDLE);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk or posedge areset) begin
    if (areset)       hist <= 2'b11;
    else if (rx_enbl) hist <= {hist[0], rx_s};
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_comb begin
    // NOTE: default assignment first, so no path leaves sample_pt unassigned and no latch is inferred.
    sample_pt = 1'b0;
    if (rx_enbl)
      sample_pt = (state == START) ? (tick_cnt == START_LAST) : (tick_cnt == BIT_LAST);
  end

  assign last_bad = stop_bad | ~bit_val;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) sync <= 2'b11;
    else        sync <= {sync[0], info};
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_en_l   <= 1'b0;
      par_odd_l  <= 1'b0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      if (dout_valid && dout_ready) dout_valid <= 1'b0;

      if (rx_enbl) begin
        if (state != IDLE)
          tick_cnt <= sample_pt ? '0 : tick_cnt + TW'(1);

        unique case (state)
          IDLE: if (!rx_s) begin
            state     <= START;
            tick_cnt  <= '0;
            par_en_l  <= p_enbl;
            par_odd_l <= p_odd;
            par_bad   <= 1'b0;
            stop_bad  <= 1'b0;
          end
          START: if (sample_pt) begin
            bit_cnt <= '0;
            state   <= bit_val ? IDLE : DATA;
          end
          DATA: if (sample_pt) begin
            shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            if (bit_cnt == BW'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= par_en_l ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
          PARITY: if (sample_pt) begin
            par_bad <= bit_val != (^shreg ^ par_odd_l);
            bit_cnt <= '0;
            state   <= STOP;
          end
          STOP: if (sample_pt) begin
            if (bit_cnt == BW'(STOP_BITS - 1)) begin
              state <= IDLE;
              // Frame end: framing beats parity beats overrun; bad frames never reach dout.
              if (last_bad)                       frame_err  <= 1'b1;
              else if (par_bad)                   parity_err <= 1'b1;
              else if (dout_valid && !dout_ready) overrun    <= 1'b1;
              else begin
                dout       <= shreg;
                dout_valid <= 1'b1;
              end
            end else begin
              stop_bad <= last_bad;
              bit_cnt  <= bit_cnt + BW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: OVERSAMPLE=16, DATA_BITS=8, STOP_BITS=1, one tick every 4 clk.
module tb_uart_rx_core;

`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  localparam int OS = 16;
  localparam int END_TICK = 9 + OS * 9 + MAJ;

  typedef enum int {EV_NONE, EV_DATA, EV_PERR, EV_FERR, EV_OVR} ev_t;
  typedef struct {
    ev_t        kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       areset;
  logic       rx_enbl = 1'b0;
  logic       info;
  logic       p_enbl;
  logic       p_odd;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic valid_prev = 1'b0;

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(1)) dut (
    .clk(clk), .areset(areset), .rx_enbl(rx_enbl), .info(info),
    .p_enbl(p_enbl), .p_odd(p_odd), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk) rx_enbl = 1'b1;
    repeat (3) @(negedge clk) rx_enbl = 1'b0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time exceeded, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic got_event(input ev_t kind, input logic [7:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("spurious_event", kind, EV_NONE);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (e.kind == EV_DATA && kind == EV_DATA) check("event_data", data, e.data);
    end
  endtask

  // Sample 1 time unit after each edge; a load is valid rising or a same-cycle accept+reload.
  always @(posedge clk) begin
    #1;
    if (!areset) begin
      if (parity_err) got_event(EV_PERR, 8'h00);
      if (frame_err)  got_event(EV_FERR, 8'h00);
      if (overrun)    got_event(EV_OVR, 8'h00);
      if (dout_valid && (!valid_prev || dout_ready)) got_event(EV_DATA, dout);
    end
    valid_prev = dout_valid;
  end

  task automatic wait_tick();
    @(posedge clk iff rx_enbl);
    @(negedge clk);
  endtask

  // Drives one frame, one line value per tick; optional ready pulse on tick ready_tick,
  // single-tick glitch at iteration glitch_m, reset abort at iteration abort_m.
  task automatic send_frame(input logic [7:0] data, input bit par_on, input bit par_val,
                            input bit stop_val, input ev_t expect_kind,
                            input int ready_tick, input int glitch_m, input int abort_m);
    int   nbits;
    int   k;
    logic b;
    exp_t e;
    if (expect_kind != EV_NONE) begin
      e.kind = expect_kind;
      e.data = data;
      exp_q.push_back(e);
    end
    nbits = 10 + (par_on ? 1 : 0);
    for (int m = 0; m < nbits * OS; m++) begin
      k = m / OS;
      wait_tick();
      if (m == ready_tick) dout_ready = 1'b0;
      if (m == abort_m) begin
        areset = 1'b1;
        repeat (3) @(negedge clk);
        info   = 1'b1;
        areset = 1'b0;
        return;
      end
      if (k == 0)                b = 1'b0;
      else if (k <= 8)           b = data[k-1];
      else if (par_on && k == 9) b = par_val;
      else                       b = stop_val;
      if (m == glitch_m) b = ~b;
      info = b;
      if (m == ready_tick - 1) begin
        repeat (3) @(negedge clk);
        dout_ready = 1'b1;
      end
    end
    wait_tick();
    info = 1'b1;
  endtask

  initial begin
    areset = 1'b1;
    info = 1'b1;
    p_enbl = 1'b0;
    p_odd = 1'b0;
    dout_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_valid_in_reset", dout_valid, 0);
    areset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_dout", dout, 0);
    check("reset_valid", dout_valid, 0);
    check("reset_errs", {parity_err, frame_err, overrun}, 0);
    check("reset_busy", busy, 0);

    // Plain frame held in the register until a one-clk ready pulse.
    send_frame(8'hA5, 0, 0, 1, EV_DATA, -1, -1, -1);
    repeat (8) @(negedge clk);
    check("a5_valid_held", dout_valid, 1);
    check("a5_dout_held", dout, 8'hA5);
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    check("a5_valid_cleared", dout_valid, 0);

    // Even parity: 0x3C has four ones, so the parity bit must be 0.
    p_enbl = 1'b1;
    send_frame(8'h3C, 1, 1, 1, EV_PERR, -1, -1, -1);
    check("perr_no_valid", dout_valid, 0);
    send_frame(8'h3C, 1, 0, 1, EV_DATA, -1, -1, -1);
    check("par_ok_dout", dout, 8'h3C);
    p_enbl = 1'b0;
    dout_ready = 1'b1;

    // Bad stop bit immediately followed by a good frame.
    send_frame(8'h5A, 0, 0, 0, EV_FERR, -1, -1, -1);
    send_frame(8'h5A, 0, 0, 1, EV_DATA, -1, -1, -1);
    check("after_ferr_dout", dout, 8'h5A);

    // False start: low for 4 ticks, then high.
    for (int m = 0; m < 4; m++) begin
      wait_tick();
      info = 1'b0;
    end
    wait_tick();
    info = 1'b1;
    check("false_start_busy", busy, 1);
    repeat (12) wait_tick();
    check("false_start_idle", busy, 0);

    // Overrun, then a completion in the same clk as an accept.
    dout_ready = 1'b0;
    send_frame(8'h11, 0, 0, 1, EV_DATA, -1, -1, -1);
    send_frame(8'h22, 0, 0, 1, EV_OVR, -1, -1, -1);
    check("ovr_dout_kept", dout, 8'h11);
    check("ovr_valid_kept", dout_valid, 1);
    send_frame(8'h22, 0, 0, 1, EV_DATA, END_TICK, -1, -1);
    check("accept_reload_dout", dout, 8'h22);
    check("accept_reload_valid", dout_valid, 1);

    // Reset during data bit 4 (line iterations 80..95).
    send_frame(8'h96, 0, 0, 1, EV_NONE, -1, -1, 85);
    check("abort_dout", dout, 0);
    check("abort_valid", dout_valid, 0);
    check("abort_busy", busy, 0);
    repeat (20) wait_tick();
    check("abort_idle_busy", busy, 0);
    check("abort_idle_errs", {parity_err, frame_err, overrun}, 0);
    dout_ready = 1'b1;
    send_frame(8'hC3, 0, 0, 1, EV_DATA, -1, -1, -1);
    check("post_abort_dout", dout, 8'hC3);
`ifdef UART_RX_MAJORITY_EN
    // Glitch visible only on the bit-2 sample tick.
    send_frame(8'hC3, 0, 0, 1, EV_DATA, -1, 56, -1);
    check("glitch_dout", dout, 8'hC3);
`endif

    repeat (40) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
